sar_search: RTL
===============

# sar_search

Successive-approximation search controller that sits around the 4-bit `compare` magnitude comparator. It drives the comparator's `in2` operand with a registered trial code and consumes the comparator's `g`/`e`/`l` result each cycle. From these it binary-searches for the unknown value on the comparator's `in1` input. It reports the found value, whether an exact match was confirmed, and whether the comparator returned an illegal flag combination.

## Interface
- `WIDTH`, 4, code width; matches the comparator operand width; must be ≥ 1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a search; accepted only in IDLE.
- `g`  in  1  comparator result: target > trial.
- `e`  in  1  comparator result: target == trial.
- `l`  in  1  comparator result: target < trial.
- `trial`  out  WIDTH  registered trial code; drives comparator `in2`.
- `busy`  out  1  high in TEST and CHECK.
- `done`  out  1  one-cycle pulse; result/flags valid.
- `result`  out  WIDTH  found value; held until the next accepted `start`.
- `exact`  out  1  `e` was observed for `result`.
- `err`  out  1  illegal comparator flags aborted the search.

## Operation
- Reset (`rst_n`=0, asynchronous, any state): state=IDLE; `trial`, `result`, accumulator `acc` and bit index = 0; `busy`, `done`, `exact` and `err` = 0.
- Comparator path is combinational. `g`/`e`/`l` are sampled at the same edge that ends the cycle in which `trial` is valid.
- A flag sample is legal only when exactly one of `g`/`e`/`l` is high.
- IDLE:
  - `start`=1 → TEST. Set `acc`=0, bit index i=WIDTH-1, `trial`=1<<(WIDTH-1). Clear `exact` and `err`.
  - Otherwise stay in IDLE; `trial` and `result` hold.
- TEST (bit i), sampling at an edge:
  - Illegal flags → DONE. `result`=`acc`, `err`=1, `exact`=0.
  - `e` → DONE. `result`=`trial`, `exact`=1 (early termination).
  - `g` → keep bit i: `acc`=`trial`.
  - `l` → drop bit i: `acc` unchanged.
  - After a `g` or `l`:
    - If i>0: i←i-1, `trial`=new `acc` | (1<<(i-1)), stay in TEST.
    - If i=0: → CHECK, `trial`=new `acc`.
- CHECK: one compare of `acc` itself. This path is reachable only for target 0.
  - Legal flags: `result`=`acc`, `exact`=`e`.
  - Illegal flags: `err`=1, `exact`=0, `result`=`acc`.
  - Either way → DONE.
- DONE: `done`=1 for exactly this cycle, then → IDLE unconditionally. `start` is ignored in DONE.
- `start` is ignored in TEST and CHECK; a search is never restarted mid-flight.
- `trial` holds its last value in DONE and IDLE.
- Arithmetic: pure bit set/clear on WIDTH-bit vectors; no carries, no overflow. Bit index is $clog2(WIDTH) wide (min 1 bit).

## Timing
- Start accepted at edge S. The first trial is valid in cycle S+1, and each TEST sample takes one cycle.
- Early termination when `e` is seen on the k-th trial (k=1..WIDTH): `done` is high in cycle S+k+1.
- Full path (target 0, WIDTH compares + CHECK): `done` is high in cycle S+WIDTH+2. For WIDTH=4 that is 6 cycles after the start edge.
- `result`, `exact` and `err` update at the same edge that raises `done`. They remain stable through IDLE until the next accepted `start`.
- `busy` rises at edge S and falls at the edge that raises `done`.
- A new `start` is accepted at the earliest in the cycle after `done`.
- Abort on illegal flags follows the same timing as an `e` termination at that sample.

## Test plan
- Bench instantiates `compare` with `in1`=target and `in2`=`trial`, `g`/`e`/`l` fed back. All cases use WIDTH=4.
- Target 10, pulse `start` → trial 8 (g), 12 (l), 10 (e); `done` in cycle S+4, `result`=10, `exact`=1, `err`=0.
- Target 0 → trials 8, 4, 2, 1 (all l), CHECK trial 0 (e); `done` in cycle S+6, `result`=0, `exact`=1; `busy` high for exactly 5 cycles.
- Sweep all targets 0..15, back-to-back starts issued the cycle after each `done` → `result`=target and `exact`=1 every time; `start` held high throughout the search is ignored while busy.
- Bench overrides flags to `g`=`e`=1 on the second sample for target 12 → `done` in cycle S+3, `err`=1, `exact`=0, `result`=8.
- Assert `rst_n`=0 asynchronously mid-TEST (target 5, after the second sample) → all outputs 0 immediately, state IDLE. After release, a new search for 5 gives `result`=5, `exact`=1.

Source files
------------

// File: rtl/sar_search_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sar_search_if : control/result bundle between a requester and the  |
// | SAR search controller, plus the comparator feedback path.          |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface sar_search_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             g;
  logic             e;
  logic             l;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             exact;
  logic             err;

  modport master (
    output start, g, e, l,
    input  trial, busy, done, result, exact, err
  );

  modport slave (
    input  start, g, e, l,
    output trial, busy, done, result, exact, err
  );
endinterface
`default_nettype wire

// File: rtl/sar_search.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sar_search : successive-approximation search around a magnitude    |
// | comparator; binary-searches the comparator's unknown operand.      |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module sar_search #(
  parameter int WIDTH = 4
) (
  input  wire           clk,
  input  wire           rst_n,
  sar_search_if.slave   bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TEST  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             exact_q, exact_d;
  logic             err_q, err_d;

  logic             w_legal;
  logic [WIDTH-1:0] w_acc_new;

  // Exactly one flag high: odd parity rules out 0 and 2, the AND rules out 3.
  assign w_legal   = (bus.g ^ bus.e ^ bus.l) & ~(bus.g & bus.e & bus.l);
  assign w_acc_new = bus.g ? trial_q : acc_q;

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    acc_d    = acc_q;
    result_d = result_q;
    idx_d    = idx_q;
    exact_d  = exact_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_TEST;
          acc_d   = '0;
          idx_d   = IW'(WIDTH - 1);
          trial_d = WIDTH'(1) << (WIDTH - 1);
          exact_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_TEST: begin
        if (!w_legal) begin
          state_d  = S_DONE;
          result_d = acc_q;
          err_d    = 1'b1;
          exact_d  = 1'b0;
        end else if (bus.e) begin
          state_d  = S_DONE;
          result_d = trial_q;
          exact_d  = 1'b1;
        end else begin
          acc_d = w_acc_new;
          if (idx_q != '0) begin
            idx_d   = idx_q - IW'(1);
            trial_d = w_acc_new | (WIDTH'(1) << (idx_q - IW'(1)));
          end else begin
            state_d = S_CHECK;
            trial_d = w_acc_new;
          end
        end
      end
      S_CHECK: begin
        state_d  = S_DONE;
        result_d = acc_q;
        exact_d  = w_legal & bus.e;
        err_d    = ~w_legal;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      trial_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      exact_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      exact_q  <= exact_d;
      err_q    <= err_d;
    end
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = (state_q == S_TEST) || (state_q == S_CHECK);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.exact  = exact_q;
  assign bus.err    = err_q;
endmodule
`default_nettype wire
